// File: rtl/id_scoreboard.sv
// id_scoreboard: decode-stage register scoreboard.
// Each register that a multi-cycle in-flight operation will write has a
// latency countdown. A decoding instruction stalls when it reads a register
// that is still counting down (RAW), or when it writes a register whose older
// pending write would complete after its own result is ready (WAW).
//
// Issue handshake: issue_valid_i is the request and issue_o is the accept.
// An instruction is consumed only in a cycle where issue_o=1. While stall_o=1
// the decoder must hold the same instruction and keep issue_valid_i asserted.
// A flush or reset cycle never accepts, even when no hazard is present.
module id_scoreboard #(
  parameter int REG_NUM    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_RD     = 2,
  parameter int LAT_W      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid_i,
  input  logic [NUM_RD-1:0]            rd_en_i,
  input  logic [NUM_RD*REG_ADDR_W-1:0] rd_addr_i,
  input  logic                         wr_en_i,
  input  logic [REG_ADDR_W-1:0]        wr_addr_i,
  input  logic [LAT_W-1:0]             wr_lat_i,
  input  logic                         flush_i,
  output logic                         stall_o,
  output logic                         issue_o,
  output logic [REG_NUM-1:0]           busy_o,
  output logic [31:0]                  stall_cnt_o
);

  // Register 0 has no countdown; it is hard-wired zero and never busy.
  logic [LAT_W-1:0]   r_cnt [1:REG_NUM-1];
  logic [31:0]        r_stall_cnt;

  logic [REG_NUM-1:0] w_busy;
  logic               w_raw;
  logic               w_waw;
  logic [LAT_W-1:0]   w_wr_cnt;
  logic               w_stall;
  logic               w_issue;
  logic               w_load;

  // A register is pending while its countdown is nonzero.
  always_comb begin
    w_busy = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      w_busy[r] = (r_cnt[r] != '0);
    end
  end

  // RAW: any enabled source port names a pending register. The address is
  // compared against every valid register index, so r0 and out-of-range
  // addresses never match.
  always_comb begin
    w_raw = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int r = 1; r < REG_NUM; r++) begin
        if (rd_en_i[k] &&
            (rd_addr_i[k*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r)) &&
            w_busy[r]) begin
          w_raw = 1'b1;
        end
      end
    end
  end

  // Remaining countdown of the destination register (0 for r0/out of range).
  always_comb begin
    w_wr_cnt = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      if (wr_addr_i == REG_ADDR_W'(r)) begin
        w_wr_cnt = r_cnt[r];
      end
    end
  end

  // WAW: the older write would land after this one, so this one must wait.
  assign w_waw   = wr_en_i && (w_wr_cnt > wr_lat_i);
  assign w_stall = issue_valid_i && (w_raw || w_waw) && !rst;
  assign w_issue = issue_valid_i && !w_stall && !flush_i && !rst;
  // Zero-latency results are forwarded normally and need no tracking.
  assign w_load  = w_issue && wr_en_i && (wr_lat_i != '0);

  // Countdown update: reset/flush clear, otherwise decrement, and a newly
  // issued multi-cycle write reloads its register (load wins over decrement).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < REG_NUM; r++) begin
        r_cnt[r] <= '0;
      end
    end else if (flush_i) begin
      for (int r = 1; r < REG_NUM; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      for (int r = 1; r < REG_NUM; r++) begin
        if (w_load && (wr_addr_i == REG_ADDR_W'(r))) begin
          r_cnt[r] <= wr_lat_i;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - 1'b1;
        end
      end
    end
  end

  // Saturating stall-cycle counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_o     = w_stall;
  assign issue_o     = w_issue;
  assign busy_o      = w_busy;
  assign stall_cnt_o = r_stall_cnt;

endmodule
